// File: rtl/model_call_sched_pkg.sv
// rtl/model_call_sched_pkg.sv - state encoding, default widths and index-width helper for model_call_sched
package model_call_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int DEF_DW      = 8;
  localparam int DEF_TIMEOUT = 16;

  // ceil(log2(n)), never below 1 so single-bit indices stay legal
  function automatic int idx_w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/model_call_sched_rr_pick.sv
// rtl/model_call_sched_rr_pick.sv - combinational round-robin picker: first set request after ptr, wrapping
module model_call_sched_rr_pick
  import model_call_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] onehot,
  output logic [IW-1:0]   idx,
  output logic            any
);

  int c;

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    c      = 0;
    // ptr itself is visited last, so the previous winner has lowest priority
    for (int i = 1; i <= NREQ; i++) begin
      c = (int'(ptr) + i) % NREQ;
      if (!any && req[c]) begin
        any       = 1'b1;
        idx       = IW'(c);
        onehot[c] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/model_call_sched.sv
// rtl/model_call_sched.sv - serialises NREQ requesters onto one model instance; watchdog under MODEL_CALL_SCHED_TIMEOUT_EN
module model_call_sched
  import model_call_sched_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int DW      = DEF_DW,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DW-1:0]       req_data,
  output logic [NREQ-1:0]          gnt,
  output logic                     mdl_start,
  output logic [DW-1:0]            mdl_in,
  input  logic                     mdl_done,
  input  logic [DW-1:0]            mdl_out,
  output logic                     rsp_valid,
  output logic [idx_w(NREQ)-1:0]   rsp_id,
  output logic [DW-1:0]            rsp_data,
  output logic                     rsp_err,
  output logic                     busy
);

  localparam int IW = idx_w(NREQ);

  state_t          state, state_nxt;
  logic [IW-1:0]   ptr, ptr_nxt;
  logic [IW-1:0]   win, win_nxt;
  logic [NREQ-1:0] gnt_nxt;
  logic [DW-1:0]   mdl_in_nxt;
  logic [IW-1:0]   rsp_id_nxt;
  logic [DW-1:0]   rsp_data_nxt;

  logic [NREQ-1:0] pick_oh;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;

  model_call_sched_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req    (req),
    .ptr    (ptr),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

`ifdef MODEL_CALL_SCHED_TIMEOUT_EN
  localparam int CW = idx_w(TIMEOUT + 1);
  logic [CW-1:0] wcnt, wcnt_nxt;
  logic          rsp_err_q, rsp_err_nxt;
  logic          expired;

  assign expired = (wcnt == CW'(TIMEOUT - 1));
  assign rsp_err = rsp_err_q;
`else
  // no watchdog: a response is never aborted
  assign rsp_err = (TIMEOUT < 0);
`endif

  assign mdl_start = (state == ISSUE);
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    win_nxt      = win;
    gnt_nxt      = gnt;
    mdl_in_nxt   = mdl_in;
    rsp_id_nxt   = rsp_id;
    rsp_data_nxt = rsp_data;
`ifdef MODEL_CALL_SCHED_TIMEOUT_EN
    wcnt_nxt     = wcnt;
    rsp_err_nxt  = rsp_err_q;
`endif
    case (state)
      IDLE: begin
        if (pick_any) begin
          state_nxt  = ISSUE;
          win_nxt    = pick_idx;
          gnt_nxt    = pick_oh;
          mdl_in_nxt = req_data[int'(pick_idx)*DW +: DW];
        end
      end
      ISSUE: begin
        state_nxt = WAIT;
`ifdef MODEL_CALL_SCHED_TIMEOUT_EN
        wcnt_nxt  = '0;
`endif
      end
      WAIT: begin
        // a real completion beats a watchdog expiry on the same edge
        if (mdl_done) begin
          state_nxt    = RESP;
          rsp_id_nxt   = win;
          rsp_data_nxt = mdl_out;
`ifdef MODEL_CALL_SCHED_TIMEOUT_EN
          rsp_err_nxt  = 1'b0;
        end else if (expired) begin
          state_nxt    = RESP;
          rsp_id_nxt   = win;
          rsp_data_nxt = '0;
          rsp_err_nxt  = 1'b1;
        end else begin
          wcnt_nxt     = wcnt + CW'(1);
`endif
        end
      end
      RESP: begin
        state_nxt = IDLE;
        ptr_nxt   = win;
        gnt_nxt   = '0;
`ifdef MODEL_CALL_SCHED_TIMEOUT_EN
        rsp_err_nxt = 1'b0;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= IW'(NREQ - 1);
      win      <= '0;
      gnt      <= '0;
      mdl_in   <= '0;
      rsp_id   <= '0;
      rsp_data <= '0;
`ifdef MODEL_CALL_SCHED_TIMEOUT_EN
      wcnt      <= '0;
      rsp_err_q <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      win      <= win_nxt;
      gnt      <= gnt_nxt;
      mdl_in   <= mdl_in_nxt;
      rsp_id   <= rsp_id_nxt;
      rsp_data <= rsp_data_nxt;
`ifdef MODEL_CALL_SCHED_TIMEOUT_EN
      wcnt      <= wcnt_nxt;
      rsp_err_q <= rsp_err_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_model_call_sched.sv
// tb/tb_model_call_sched.sv - scoreboard bench for model_call_sched with a model stub and RR reference
module tb_model_call_sched;

  localparam int NREQ    = 4;
  localparam int DW      = 8;
  localparam int TIMEOUT = 16;
  localparam int IW      = $clog2(NREQ);

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [NREQ-1:0]        req = '0;
  logic [NREQ*DW-1:0]     req_data = '0;
  logic                   mdl_done = 1'b0;
  logic [DW-1:0]          mdl_out = '0;
  logic [NREQ-1:0]        gnt;
  logic                   mdl_start;
  logic [DW-1:0]          mdl_in;
  logic                   rsp_valid;
  logic [IW-1:0]          rsp_id;
  logic [DW-1:0]          rsp_data;
  logic                   rsp_err;
  logic                   busy;

  model_call_sched #(.NREQ(NREQ), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .gnt(gnt),
    .mdl_start(mdl_start), .mdl_in(mdl_in), .mdl_done(mdl_done), .mdl_out(mdl_out),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int id;
    int data;
    int err;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   grant_log[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  logic [NREQ-1:0]    req_e = '0;
  logic [NREQ*DW-1:0] data_e = '0;
  logic               rst_e = 1'b0;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    req_e  <= req;
    data_e <= req_data;
    rst_e  <= rst_n;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic int rr_ref(input logic [NREQ-1:0] r, input int p);
    for (int k = 1; k <= NREQ; k++)
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  // reference state and monitor
  int              ref_ptr = NREQ - 1;
  int              cur_win = 0;
  logic [DW-1:0]   cur_op = '0;
  bit              in_txn = 0;
  int              start_cnt = 0;
  int              start_seen = 0;
  int              rsp_count = 0;
  int              last_id = 0, last_data = 0, last_err = 0;
  logic [NREQ-1:0] last_gnt = '0;
  logic [NREQ-1:0] prev_gnt = '0;
  logic [DW-1:0]   last_start_in = '0;
  int              mw;
  exp_t            me;

  always @(negedge clk) begin
    if (!rst_e) begin
      sb.delete();
      in_txn  = 0;
      ref_ptr = NREQ - 1;
    end else begin
      if (gnt != '0 && prev_gnt == '0) begin
        mw = rr_ref(req_e, ref_ptr);
        check("grant_winner", 32'(gnt), (mw < 0) ? 32'd0 : (32'd1 << mw));
        cur_win   = (mw < 0) ? 0 : mw;
        cur_op    = data_e[cur_win*DW +: DW];
        in_txn    = 1;
        start_cnt = 0;
        last_gnt  = gnt;
        grant_log.push_back(mw);
      end else if (gnt != '0 && !in_txn) begin
        check("gnt_stuck", 32'(gnt), 32'd0);
      end
      if (in_txn) begin
        check("gnt_hold", 32'(gnt), 32'd1 << cur_win);
        check("mdl_in_stable", 32'(mdl_in), 32'(cur_op));
      end
      if (mdl_start) begin
        start_cnt++;
        start_seen++;
        last_start_in = mdl_in;
      end
      if (rsp_valid) begin
        rsp_count++;
        last_id   = int'(rsp_id);
        last_data = int'(rsp_data);
        last_err  = int'(rsp_err);
        if (sb.size() == 0) begin
          check("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          me = sb.pop_front();
          check("rsp_id", 32'(rsp_id), me.id);
          check("rsp_data", 32'(rsp_data), me.data);
          check("rsp_err", 32'(rsp_err), me.err);
          check("rsp_latency", cyc, me.cyc);
          check("start_pulses", start_cnt, 32'd1);
        end
        if (in_txn) ref_ptr = cur_win;
        in_txn = 0;
      end
    end
    prev_gnt = gnt;
  end

  // model stub: answers each start after a chosen delay
  int            fixed_delay = -1;
  bit            fixed_out_en = 0;
  logic [DW-1:0] fixed_out = '0;
  bit            hang = 0;
  bit            spur_en = 0;
  bit            spur_issue = 0;
  bit            inject_done = 0;
  int            wcnt = -1;

  initial begin
    forever begin
      @(negedge clk);
      mdl_done = 1'b0;
      if (!rst_e) begin
        wcnt = -1;
      end else if (mdl_start) begin
        if (hang) begin
          wcnt = -2;
`ifdef MODEL_CALL_SCHED_TIMEOUT_EN
          sb.push_back('{cur_win, 0, 1, cyc + TIMEOUT + 1});
`endif
        end else begin
          wcnt = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 4));
        end
        if (spur_issue || (spur_en && $urandom_range(0, 3) == 0)) begin
          mdl_done   = 1'b1;
          mdl_out    = DW'($urandom);
          spur_issue = 0;
        end
      end else if (wcnt == 0) begin
        mdl_done = 1'b1;
        mdl_out  = fixed_out_en ? fixed_out : DW'($urandom);
        sb.push_back('{cur_win, int'(mdl_out), 0, cyc + 1});
        wcnt = -1;
      end else if (wcnt > 0) begin
        wcnt--;
      end else if (inject_done || (spur_en && $urandom_range(0, 5) == 0)) begin
        mdl_done    = 1'b1;
        mdl_out     = DW'($urandom);
        inject_done = 0;
      end
    end
  end

  task automatic wait_rsp(input string name, input int n, input int budget);
    int t;
    t = 0;
    while (rsp_count < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    check(name, 32'(rsp_count >= n), 32'd1);
  endtask

  task automatic wait_gnt(input string name, input int budget);
    int t;
    t = 0;
    while (gnt == '0 && t < budget) begin
      @(negedge clk);
      t++;
    end
    check(name, 32'(gnt != '0), 32'd1);
  endtask

  function automatic logic [31:0] outs_packed();
    return 32'({gnt, mdl_start, mdl_in, rsp_valid, rsp_id, rsp_data, rsp_err, busy});
  endfunction

  logic [NREQ-1:0] pending = '0;

  task automatic rand_step(input bit allow_new);
    if (rsp_valid) begin
      req[rsp_id]     = 1'b0;
      pending[rsp_id] = 1'b0;
    end
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        if (req[i] && $urandom_range(0, 7) == 0) req[i] = 1'b0;
        req_data[i*DW +: DW] = DW'($urandom);
      end else if (!pending[i]) begin
        req_data[i*DW +: DW] = DW'($urandom);
        if (allow_new && $urandom_range(0, 3) == 0) begin
          pending[i] = 1'b1;
          req[i]     = 1'b1;
        end
      end
    end
  endtask

  int base;
  int s0;
  int busy_low;
  int exp_order[5] = '{0, 1, 2, 3, 0};

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", outs_packed(), 32'd0);
    rst_n = 1'b1;

    // single call
    @(negedge clk);
    req_data[2*DW +: DW] = 8'h3C;
    req[2]       = 1'b1;
    fixed_delay  = 2;
    fixed_out    = 8'hA5;
    fixed_out_en = 1;
    base = rsp_count;
    s0   = start_seen;
    wait_rsp("single_rsp_wait", base + 1, 50);
    req[2] = 1'b0;
    check("single_gnt", 32'(last_gnt), 32'h4);
    check("single_starts", start_seen - s0, 32'd1);
    check("single_mdl_in", 32'(last_start_in), 32'h3C);
    check("single_id", last_id, 32'd2);
    check("single_data", last_data, 32'hA5);
    check("single_err", last_err, 32'd0);
    fixed_out_en = 0;

    // withdrawal after grant plus a done pulse during ISSUE
    @(negedge clk);
    req_data[1*DW +: DW] = DW'($urandom);
    req[1]      = 1'b1;
    spur_issue  = 1;
    fixed_delay = 1;
    base = rsp_count;
    wait_gnt("withdraw_gnt_wait", 20);
    @(negedge clk);
    req[1] = 1'b0;
    wait_rsp("withdraw_rsp_wait", base + 1, 50);
    repeat (10) @(negedge clk);
    check("withdraw_one_rsp", rsp_count, base + 1);
    check("withdraw_id", last_id, 32'd1);

    // reset while waiting on the model
    hang = 1;
    req_data[3*DW +: DW] = DW'($urandom);
    req[3] = 1'b1;
    base = rsp_count;
    wait_gnt("rstmid_gnt_wait", 20);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
    @(negedge clk);
    check("rstmid_outputs", outs_packed(), 32'd0);
    rst_n = 1'b1;
    hang  = 0;
    @(negedge clk);
    inject_done = 1;
    repeat (6) @(negedge clk);
    check("rstmid_no_rsp", rsp_count, base);

    // fairness with every requester held high
    fixed_delay = 0;
    grant_log.delete();
    for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = DW'($urandom);
    req = '1;
    for (int t = 0; t < 100 && grant_log.size() < 5; t++) @(negedge clk);
    req = '0;
    check("fair_grant_count", 32'(grant_log.size() >= 5), 32'd1);
    for (int i = 0; i < 5; i++)
      check("fair_order", (i < grant_log.size()) ? grant_log[i] : -1, exp_order[i]);
    for (int t = 0; t < 50 && busy; t++) @(negedge clk);
    check("fair_idle", 32'(busy), 32'd0);

`ifdef MODEL_CALL_SCHED_TIMEOUT_EN
    // watchdog abort, then a late done
    hang = 1;
    req_data[3*DW +: DW] = DW'($urandom);
    req[3] = 1'b1;
    base = rsp_count;
    wait_rsp("wd_rsp_wait", base + 1, 60);
    req[3] = 1'b0;
    check("wd_err", last_err, 32'd1);
    check("wd_data", last_data, 32'd0);
    inject_done = 1;
    repeat (6) @(negedge clk);
    check("wd_late_done", rsp_count, base + 1);
    hang = 0;

    // done on the expiry edge wins
    fixed_delay  = TIMEOUT - 1;
    fixed_out    = 8'h77;
    fixed_out_en = 1;
    req_data[0*DW +: DW] = DW'($urandom);
    req[0] = 1'b1;
    base = rsp_count;
    wait_rsp("wd_corner_wait", base + 1, 60);
    req[0] = 1'b0;
    check("wd_corner_err", last_err, 32'd0);
    check("wd_corner_data", last_data, 32'h77);
    fixed_out_en = 0;
`else
    // no watchdog: a model that never finishes holds the scheduler
    hang = 1;
    req_data[3*DW +: DW] = DW'($urandom);
    req[3] = 1'b1;
    wait_gnt("hang_gnt_wait", 20);
    base     = rsp_count;
    busy_low = 0;
    repeat (100) begin
      @(negedge clk);
      if (!busy) busy_low++;
    end
    check("hang_busy", busy_low, 32'd0);
    check("hang_no_rsp", rsp_count, base);
    rst_n = 1'b0;
    req   = '0;
    @(negedge clk);
    rst_n = 1'b1;
    hang  = 0;
`endif

    // randomized traffic with spurious strobes
    fixed_delay = -1;
    spur_en     = 1;
    pending     = '0;
    req         = '0;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      rand_step(1'b1);
    end
    for (int t = 0; t < 500 && (pending != '0 || busy); t++) begin
      @(negedge clk);
      rand_step(1'b0);
    end
    spur_en = 0;
    repeat (4) @(negedge clk);
    check("drain_pending", 32'(pending), 32'd0);
    check("drain_scoreboard", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    failures++;
    $display("FAIL global_timeout actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
